// File: rtl/fifo_uart_pkg.sv
// Shared encodings and defaults for the FIFO-draining UART transmitter.
package fifo_uart_pkg;

    localparam int unsigned DEFAULT_CLKS_PER_BIT = 16;

    localparam logic [2:0] STATE_IDLE  = 3'd0;
    localparam logic [2:0] STATE_FETCH = 3'd1;
    localparam logic [2:0] STATE_LOAD  = 3'd2;
    localparam logic [2:0] STATE_START = 3'd3;
    localparam logic [2:0] STATE_DATA  = 3'd4;
    localparam logic [2:0] STATE_STOP  = 3'd5;

    typedef enum logic [2:0] {
        IDLE  = STATE_IDLE,
        FETCH = STATE_FETCH,
        LOAD  = STATE_LOAD,
        START = STATE_START,
        DATA  = STATE_DATA,
        STOP  = STATE_STOP
    } state_t;

endpackage

// File: rtl/uart_baud_gen.sv
// Bit-period counter: counts 0..CLKS_PER_BIT-1 and flags the last cycle of each bit.
module uart_baud_gen
    import fifo_uart_pkg::*;
#(
    parameter int unsigned CLKS_PER_BIT = DEFAULT_CLKS_PER_BIT,
    parameter int unsigned CNT_W        = (CLKS_PER_BIT > 1) ? $clog2(CLKS_PER_BIT) : 1
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             clear,
    output logic [CNT_W-1:0] count,
    output logic             tick
);

    assign tick = (count == CNT_W'(CLKS_PER_BIT - 1));

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            count <= '0;
        end else if (clear || tick) begin
            count <= '0;
        end else begin
            count <= count + CNT_W'(1);
        end
    end

endmodule

// File: rtl/fifo_uart_tx.sv
// Pops bytes from the synchronous FIFO and serialises each one as a UART 8N1 frame.
module fifo_uart_tx
    import fifo_uart_pkg::*;
#(
    parameter int unsigned DATA_WIDTH   = 8,
    parameter int unsigned CLKS_PER_BIT = DEFAULT_CLKS_PER_BIT
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic                  enable,
    input  logic                  fifo_empty,
    input  logic [DATA_WIDTH-1:0] fifo_data,
    output logic                  fifo_read_en,
    output logic                  tx,
    output logic                  busy,
    output logic                  tx_done,
    output logic [15:0]           frame_count
);

    localparam int unsigned CNT_W = (CLKS_PER_BIT > 1) ? $clog2(CLKS_PER_BIT) : 1;
    localparam int unsigned BIT_W = (DATA_WIDTH > 1) ? $clog2(DATA_WIDTH) : 1;

    state_t                state;
    logic [DATA_WIDTH-1:0] shift_q;
    logic [BIT_W-1:0]      bit_idx;
    logic [15:0]           frame_cnt_q;
    logic [CNT_W-1:0]      baud_cnt;
    logic                  tick;
    logic                  baud_clear;
    logic                  frame_end;

    // Baud counter only runs while a frame is on the line.
    assign baud_clear = (state == IDLE) || (state == FETCH) || (state == LOAD);
    assign frame_end  = (state == STOP) && tick;

    uart_baud_gen #(
        .CLKS_PER_BIT(CLKS_PER_BIT),
        .CNT_W       (CNT_W)
    ) u_baud (
        .clk  (clk),
        .rst  (rst),
        .clear(baud_clear),
        .count(baud_cnt),
        .tick (tick)
    );

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state        <= IDLE;
            shift_q      <= '0;
            bit_idx      <= '0;
            fifo_read_en <= 1'b0;
            tx           <= 1'b1;
            busy         <= 1'b0;
            tx_done      <= 1'b0;
        end else begin
            fifo_read_en <= 1'b0;
            tx_done      <= 1'b0;
            case (state)
                IDLE: begin
                    tx <= 1'b1;
                    if (enable && !fifo_empty) begin
                        state        <= FETCH;
                        fifo_read_en <= 1'b1;
                        busy         <= 1'b1;
                    end
                end
                FETCH: state <= LOAD;
                LOAD: begin
                    shift_q <= fifo_data;
                    bit_idx <= '0;
                    tx      <= 1'b0;
                    state   <= START;
                end
                START: begin
                    if (tick) begin
                        tx    <= shift_q[0];
                        state <= DATA;
                    end
                end
                DATA: begin
                    if (tick) begin
                        if (bit_idx == BIT_W'(DATA_WIDTH - 1)) begin
                            tx    <= 1'b1;
                            state <= STOP;
                        end else begin
                            bit_idx <= bit_idx + BIT_W'(1);
                            shift_q <= shift_q >> 1;
                            tx      <= shift_q[1];
                        end
                    end
                end
                STOP: begin
                    // Raise tx_done one cycle early so it lands on the final stop cycle.
                    if (baud_cnt == CNT_W'(CLKS_PER_BIT - 2)) begin
                        tx_done <= 1'b1;
                    end
                    if (tick) begin
                        busy  <= 1'b0;
                        state <= IDLE;
                    end
                end
                default: begin
                    state <= IDLE;
                    tx    <= 1'b1;
                    busy  <= 1'b0;
                end
            endcase
        end
    end

    // Frame counter, wraps naturally at 16 bits.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            frame_cnt_q <= '0;
        end else begin
            frame_cnt_q <= frame_cnt_q + 16'(frame_end);
        end
    end

    assign frame_count = frame_cnt_q;

endmodule

// File: tb/tb_fifo_uart_tx.sv
// Directed bench for fifo_uart_tx with a behavioural synchronous FIFO in front of it.
module tb_fifo_uart_tx;
    import fifo_uart_pkg::*;

    localparam int unsigned CPB = 4;

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic        enable = 1'b0;
    logic        fifo_empty = 1'b1;
    logic [7:0]  fifo_data = 8'h00;
    logic        fifo_read_en;
    logic        tx;
    logic        busy;
    logic        tx_done;
    logic [15:0] frame_count;

    logic        wr_en = 1'b0;
    logic [7:0]  wr_data = 8'h00;
    logic        flush = 1'b0;
    logic [7:0]  q[$];

    int n_cmp = 0;
    int n_bad = 0;
    int rd_pulses = 0;
    int rd_bad = 0;
    int done_pulses = 0;

    fifo_uart_tx #(.DATA_WIDTH(8), .CLKS_PER_BIT(CPB)) dut (
        .clk         (clk),
        .rst         (rst),
        .enable      (enable),
        .fifo_empty  (fifo_empty),
        .fifo_data   (fifo_data),
        .fifo_read_en(fifo_read_en),
        .tx          (tx),
        .busy        (busy),
        .tx_done     (tx_done),
        .frame_count (frame_count)
    );

    always #5 clk = ~clk;

    // One-cycle read latency FIFO, same behaviour as Synchronous_FIFO.
    always @(posedge clk) begin
        if (flush) begin
            q.delete();
        end else if (fifo_read_en && q.size() != 0) begin
            fifo_data <= q[0];
            void'(q.pop_front());
        end
        if (wr_en) q.push_back(wr_data);
        fifo_empty <= (q.size() == 0);
    end

    always @(negedge clk) begin
        if (fifo_read_en) rd_pulses++;
        if (fifo_read_en && fifo_empty) rd_bad++;
        if (tx_done) done_pulses++;
    end

    initial begin
        #500000;
        $display("FAIL timeout: observed=no finish expected=finish");
        $fatal(1, "timeout");
    end

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_cmp++;
        assert (obs === exp) else begin
            n_bad++;
            $error("FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic push(input logic [7:0] v);
        @(negedge clk);
        wr_en   = 1'b1;
        wr_data = v;
        @(negedge clk);
        wr_en   = 1'b0;
    endtask

    task automatic flush_fifo();
        @(negedge clk);
        flush = 1'b1;
        @(negedge clk);
        flush = 1'b0;
    endtask

    task automatic pulse_reset();
        @(negedge clk);
        rst = 1'b0;
        #2;
        rst = 1'b1;
    endtask

    // Returns at the negedge where tx is first seen low; nhigh = high samples before it.
    task automatic wait_start(input int budget, output int nhigh, output bit found);
        nhigh = 0;
        found = 1'b0;
        for (int i = 0; i < budget; i++) begin
            @(negedge clk);
            if (tx === 1'b0) begin
                found = 1'b1;
                break;
            end
            nhigh++;
        end
    endtask

    // seq[i] is line bit i (start, d0..d7, stop); first sample taken at the current negedge.
    task automatic check_frame(input logic [9:0] seq, input string tag, input int drop_at);
        int         errs;
        logic [7:0] rx;
        errs = 0;
        rx   = 8'h00;
        for (int k = 0; k < 40; k++) begin
            if (k > 0) @(negedge clk);
            if (k == drop_at) enable = 1'b0;
            if (tx !== seq[k/4]) errs++;
            if (tx_done !== (k == 39)) errs++;
            if ((k % 4) == 2 && k >= 4 && k < 36) rx[k/4-1] = tx;
        end
        chk({tag, " data"}, 32'(rx), 32'(seq[8:1]));
        chk({tag, " timing"}, errs, 0);
    endtask

    function automatic logic [9:0] frame_of(input logic [7:0] b);
        return {1'b1, b, 1'b0};
    endfunction

    initial begin
        int  nhigh;
        bit  found;
        int  tx_low;
        int  busy_hi;
        int  rd0;
        int  dn0;

        // Reset then idle with an empty FIFO
        enable = 1'b1;
        #1 rst = 1'b0;
        #3;
        chk("reset tx", 32'(tx), 32'd1);
        chk("reset busy", 32'(busy), 32'd0);
        chk("reset read_en", 32'(fifo_read_en), 32'd0);
        chk("reset tx_done", 32'(tx_done), 32'd0);
        chk("reset frame_count", 32'(frame_count), 32'd0);
        #3 rst = 1'b1;
        tx_low = 0;
        busy_hi = 0;
        for (int i = 0; i < 200; i++) begin
            @(negedge clk);
            if (tx !== 1'b1) tx_low++;
            if (busy !== 1'b0) busy_hi++;
        end
        #1;
        chk("idle tx low cycles", tx_low, 0);
        chk("idle busy cycles", busy_hi, 0);
        chk("idle read pulses", rd_pulses, 0);
        chk("idle frame_count", 32'(frame_count), 32'd0);

        // Single byte 0xA5
        rd0 = rd_pulses;
        dn0 = done_pulses;
        push(8'hA5);
        @(negedge clk);
        chk("a5 fetch pulse", 32'(fifo_read_en), 32'd1);
        @(negedge clk);
        chk("a5 load tx high", 32'(tx), 32'd1);
        chk("a5 load read_en", 32'(fifo_read_en), 32'd0);
        @(negedge clk);
        check_frame(10'b1101001010, "a5", -1);
        @(negedge clk);
        chk("a5 frame_count", 32'(frame_count), 32'd1);
        chk("a5 busy after", 32'(busy), 32'd0);
        #1;
        chk("a5 read pulses", rd_pulses - rd0, 1);
        chk("a5 done pulses", done_pulses - dn0, 1);

        // Back-to-back drain of 0..9
        pulse_reset();
        enable = 1'b0;
        for (int i = 0; i < 10; i++) push(8'(i));
        #1;
        rd0 = rd_pulses;
        rd_bad = 0;
        @(negedge clk);
        enable = 1'b1;
        for (int i = 0; i < 10; i++) begin
            wait_start(60, nhigh, found);
            chk($sformatf("b2b start %0d", i), 32'(found), 32'd1);
            if (i > 0) chk($sformatf("b2b gap %0d", i), nhigh, 3);
            check_frame(frame_of(8'(i)), $sformatf("b2b byte %0d", i), -1);
        end
        @(negedge clk);
        chk("b2b frame_count", 32'(frame_count), 32'd10);
        #1;
        chk("b2b read pulses", rd_pulses - rd0, 10);
        chk("b2b read while empty", rd_bad, 0);

        // Enable dropped during DATA of 0x3C, more bytes queued
        enable = 1'b0;
        push(8'h3C);
        push(8'h11);
        push(8'h22);
        #1;
        rd0 = rd_pulses;
        @(negedge clk);
        enable = 1'b1;
        wait_start(20, nhigh, found);
        chk("drop start", 32'(found), 32'd1);
        check_frame(frame_of(8'h3C), "drop 3c", 12);
        @(negedge clk);
        chk("drop busy after stop", 32'(busy), 32'd0);
        tx_low = 0;
        busy_hi = 0;
        for (int i = 0; i < 50; i++) begin
            @(negedge clk);
            if (tx !== 1'b1) tx_low++;
            if (busy !== 1'b0) busy_hi++;
        end
        #1;
        chk("drop no new frame", tx_low, 0);
        chk("drop stays idle", busy_hi, 0);
        chk("drop read pulses", rd_pulses - rd0, 1);
        chk("drop frame_count", 32'(frame_count), 32'd11);
        flush_fifo();

        // Reset during bit 3 of 0xFF, next byte 0x5A queued
        push(8'hFF);
        push(8'h5A);
        @(negedge clk);
        enable = 1'b1;
        wait_start(20, nhigh, found);
        chk("rstmid start", 32'(found), 32'd1);
        for (int k = 1; k <= 17; k++) @(negedge clk);
        rst = 1'b0;
        #1;
        chk("rstmid tx", 32'(tx), 32'd1);
        chk("rstmid busy", 32'(busy), 32'd0);
        chk("rstmid read_en", 32'(fifo_read_en), 32'd0);
        chk("rstmid frame_count", 32'(frame_count), 32'd0);
        chk("rstmid state", 32'(dut.state), 32'(STATE_IDLE));
        #2 rst = 1'b1;
        wait_start(20, nhigh, found);
        chk("rstmid refetch start", 32'(found), 32'd1);
        check_frame(frame_of(8'h5A), "rstmid 5a", -1);
        @(negedge clk);
        chk("rstmid frame_count after", 32'(frame_count), 32'd1);

        // Frame counter wrap
        @(negedge clk);
        force dut.frame_cnt_q = 16'hFFFF;
        @(posedge clk);
        @(negedge clk);
        release dut.frame_cnt_q;
        @(negedge clk);
        chk("wrap preset", 32'(frame_count), 32'h0000FFFF);
        #1;
        dn0 = done_pulses;
        push(8'h81);
        wait_start(20, nhigh, found);
        chk("wrap start", 32'(found), 32'd1);
        check_frame(frame_of(8'h81), "wrap 81", -1);
        @(negedge clk);
        chk("wrap frame_count", 32'(frame_count), 32'd0);
        #1;
        chk("wrap done pulses", done_pulses - dn0, 1);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule

// File: doc/fifo_uart_tx.md
# fifo_uart_tx

Downstream drain stage for `Synchronous_FIFO`. It pops 8-bit bytes from the FIFO whenever the FIFO is non-empty and enabled, then serialises each byte as a UART 8N1 frame on `tx`. It sits between the FIFO's read port (`read_en`/`data_out`/`FIFO_empty`) and the chip's serial output pin. It owns the FIFO's `read_en`; nothing else reads the FIFO.

## Interface
- `DATA_WIDTH`, default 8: byte width. It must match the FIFO data width.
- `CLKS_PER_BIT`, default 16: clock cycles per UART bit. Legal values are 2 or more.
- `clk`  in  1: single clock. Everything is rising-edge.
- `rst`  in  1: reset, asynchronous, active-low.
- `enable`  in  1: permits starting a new frame. It is sampled only in IDLE.
- `fifo_empty`  in  1: driven from the FIFO's `FIFO_empty`.
- `fifo_data`  in  DATA_WIDTH: driven from the FIFO's `data_out`.
- `fifo_read_en`  out  1: drives the FIFO's `read_en`. Registered, with a one-cycle pulse per byte.
- `tx`  out  1: serial line. It idles high.
- `busy`  out  1: high in every state except IDLE.
- `tx_done`  out  1: one-cycle pulse in the last cycle of the stop bit.
- `frame_count`  out  16: number of completed frames. Wraps from 0xFFFF to 0.

## Operation
- States: IDLE, FETCH, LOAD, START, DATA, STOP.
- IDLE: `tx`=1. If `enable` && !`fifo_empty`, go to FETCH; otherwise stay.
- FETCH (1 cycle): `fifo_read_en`=1. The FIFO updates `data_out` on the edge that ends this cycle. Next state is LOAD.
- LOAD (1 cycle): capture `fifo_data` into the shift register, clear the baud and bit counters, then go to START.
- START: `tx`=0 for CLKS_PER_BIT cycles, then go to DATA.
- DATA: shift out DATA_WIDTH bits, LSB first, each held CLKS_PER_BIT cycles. After bit DATA_WIDTH-1, go to STOP.
- STOP: `tx`=1 for CLKS_PER_BIT cycles. In the final cycle, `tx_done`=1 and `frame_count` increments. Then go to IDLE.
- Baud counter: width $clog2(CLKS_PER_BIT). It counts 0..CLKS_PER_BIT-1 and produces a bit tick at CLKS_PER_BIT-1.
- Bit index: width $clog2(DATA_WIDTH).
- `fifo_read_en` is never asserted while `fifo_empty`=1 was sampled in IDLE. It is never asserted outside FETCH.
- `fifo_empty` and `enable` are ignored in all states except IDLE. Deasserting `enable` mid-frame completes the current frame and starts no new one.
- Reset (asserted at any time, including mid-frame) immediately forces:
  - state IDLE;
  - `tx`=1, `fifo_read_en`=0, `busy`=0, `tx_done`=0;
  - `frame_count`=0, counters=0, shift register=0.
  - The partially sent byte is lost; it is not re-read.
- Reset values of all outputs: `tx`=1, `fifo_read_en`=0, `busy`=0, `tx_done`=0, `frame_count`=0.

## Timing
- FIFO read latency is 1 cycle: data is valid in the cycle after `fifo_read_en` is high.
- Let cycle n be the IDLE cycle in which the fetch condition is true:
  - `fifo_read_en` is high in cycle n+1;
  - LOAD occurs in n+2;
  - the `tx` falling edge (start bit) is at the start of cycle n+3.
- Frame length is (DATA_WIDTH+2)·CLKS_PER_BIT cycles of `tx` activity.
- Back-to-back frames have a fixed 3-cycle `tx`-high gap between the end of the stop bit and the next start bit (IDLE + FETCH + LOAD).
- `tx_done` and the `frame_count` update occur in the same cycle. The new count is visible from the next cycle.

## Structure
- Package `fifo_uart_pkg` holds the state encoding localparams (IDLE..STOP, 3-bit) and the default CLKS_PER_BIT.
- Sub-module `uart_baud_gen`: a counter with a `clear` input and a `tick` output, parameterised by CLKS_PER_BIT. It is instantiated once.
- The FSM, shift register and frame counter live in the top module.

## Test plan
- Reset then idle: hold `rst`=0 for 6 ns, then release with `fifo_empty`=1 and `enable`=1 for 200 cycles. Required: `tx`=1, `fifo_read_en` never high, `busy`=0, `frame_count`=0.
- Single byte with CLKS_PER_BIT=4: FIFO holds 0xA5. Required:
  - exactly one `fifo_read_en` pulse;
  - `tx` sequence 0,1,0,1,0,0,1,0,1,1, each bit held 4 cycles;
  - `tx_done` pulses once;
  - `frame_count`=1.
- Back-to-back drain: FIFO pre-filled with 0..9 by the FIFO bench pattern. Required:
  - 10 frames carrying 0x00..0x09 in order;
  - 3-cycle gaps between frames;
  - `frame_count`=10;
  - `fifo_read_en` pulses exactly 10 times, and never while `fifo_empty`=1.
- Enable drop mid-frame: deassert `enable` during the DATA state of byte 0x3C with more bytes queued. Required: 0x3C completes, no further FETCH, `busy` falls after STOP.
- Reset mid-frame: assert `rst` during bit 3 of 0xFF. Required:
  - `tx`=1 asynchronously;
  - state IDLE, `frame_count`=0;
  - after release, the next queued byte is fetched normally.
- Counter wrap: force `frame_count` to 0xFFFF, then send one frame. Required: `frame_count`=0x0000 and `tx_done` pulses once.
